// File: rtl/result_framer.sv
// result_framer: buffers a no-backpressure sample stream and emits frames of
// sequence header, FRAME_LEN payload bytes and a zero-sum checksum byte.
module result_framer #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                   i_clk,
    input  logic                   rstn,
    input  logic                   i_valid,
    input  logic [7:0]             i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [7:0]             o_data,
    output logic                   o_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    input  logic                   clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [LW-1:0] FLEN      = LW'(FRAME_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
    state_t state, state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_next;
    logic [BW-1:0] beat;
    logic [7:0]    seq, sum, head;
    logic          push, pop, drop, hs;

    assign head = mem[rd_ptr];
    assign hs   = o_valid && o_ready;
    assign pop  = (state == PAY) && o_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still accept
    assign push = i_valid && ((level < FULL) || pop);
    assign drop = i_valid && !push;
    assign level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
        end
    end

    // A clear coinciding with a drop keeps that drop visible
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= {7'd0, drop};
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Frames start only once a full payload is buffered, counting this cycle's write
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (level_next >= FLEN) state_next = HDR;
            HDR:     if (o_ready) state_next = PAY;
            PAY:     if (o_ready && beat == LAST_BEAT) state_next = CSUM;
            CSUM:    if (o_ready) state_next = (level_next >= FLEN) ? HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            beat <= '0;
            sum  <= 8'h00;
            seq  <= 8'h00;
        end else if (hs) begin
            case (state)
                HDR: begin
                    sum  <= seq;
                    beat <= '0;
                end
                PAY: begin
                    sum  <= sum + head;
                    beat <= beat + 1'b1;
                end
                CSUM:    seq <= seq + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = 8'h00;
        case (state)
            HDR: begin
                o_valid = 1'b1;
                o_data  = seq;
            end
            PAY: begin
                o_valid = 1'b1;
                o_data  = head;
            end
            CSUM: begin
                o_valid = 1'b1;
                o_last  = 1'b1;
                o_data  = 8'h00 - sum;
            end
            default: ;
        endcase
    end
endmodule
